// File: rtl/axi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_pkg : shared burst encodings, FSM states and helper function  |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int c_BOUNDARY_BITS = 12;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_beat_gen_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_beat_gen_if : command and beat handshake bundle               |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
interface axi_beat_gen_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 4
);
  localparam int DSZ = $clog2(DW / 8);
  localparam int LW  = (DSZ > 1) ? DSZ : 1;

  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [IDW-1:0] i_cmd_id;
  logic [AW-1:0]  i_cmd_addr;
  logic [7:0]     i_cmd_len;
  logic [2:0]     i_cmd_size;
  logic [1:0]     i_cmd_burst;
  logic           o_beat_valid;
  logic           i_beat_ready;
  logic [IDW-1:0] o_beat_id;
  logic [AW-1:0]  o_beat_addr;
  logic [LW-1:0]  o_beat_lane;
  logic [7:0]     o_beat_idx;
  logic           o_beat_last;
  logic           o_beat_err;
  logic           o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd_id, i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_burst,
    input  i_beat_ready,
    output o_cmd_ready,
    output o_beat_valid, o_beat_id, o_beat_addr, o_beat_lane, o_beat_idx,
    output o_beat_last, o_beat_err, o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd_id, i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_burst,
    output i_beat_ready,
    input  o_cmd_ready,
    input  o_beat_valid, o_beat_id, o_beat_addr, o_beat_lane, o_beat_idx,
    input  o_beat_last, o_beat_err, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/axi_next_addr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_next_addr : combinational next-beat address and byte lane     |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module axi_next_addr
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [AW-1:0]                            i_addr,
  input  logic [2:0]                               i_size,
  input  logic [7:0]                               i_len,
  input  burst_e                                   i_burst,
  output logic [AW-1:0]                            o_next_addr,
  output logic                                     o_cross,
  output logic [(($clog2(DW/8) > 1) ? $clog2(DW/8) : 1)-1:0] o_lane
);
  localparam int DSZ   = $clog2(DW / 8);
  localparam int c_LSW = c_BOUNDARY_BITS + 1;
  localparam logic [AW-1:0] c_LOW_MASK = AW'((1 << c_BOUNDARY_BITS) - 1);

  logic [AW-1:0]    w_inc;
  logic [AW-1:0]    w_align_mask;
  logic [AW-1:0]    w_aligned;
  logic [AW-1:0]    w_sum;
  logic [AW-1:0]    w_wrap_mask;
  logic [c_LSW-1:0] w_low_sum;

  always_comb begin
    w_inc        = AW'(1) << i_size;
    w_align_mask = w_inc - AW'(1);
    w_aligned    = i_addr & ~w_align_mask;
    w_sum        = w_aligned + w_inc;
    w_wrap_mask  = ((AW'(i_len) + AW'(1)) << i_size) - AW'(1);
    // The extra top bit of the low-page sum is the carry into the 4 KB page
    w_low_sum    = {1'b0, w_aligned[c_BOUNDARY_BITS-1:0]} + c_LSW'(w_inc[7:0]);
    o_cross      = 1'b0;
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_sum & w_wrap_mask);
      default: begin
        o_next_addr = (i_addr & ~c_LOW_MASK) | AW'(w_low_sum[c_BOUNDARY_BITS-1:0]);
        o_cross     = w_low_sum[c_BOUNDARY_BITS];
      end
    endcase
  end

  generate
    if (DSZ == 0) begin : g_lane_none
      assign o_lane = '0;
    end else begin : g_lane_bits
      assign o_lane = i_addr[DSZ-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_beat_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_beat_gen : queued AXI burst command to per-beat address gen   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module axi_beat_gen
  import axi_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int IDW    = 4,
  parameter int QDEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  axi_beat_gen_if.slave bus
);
  localparam int DSZ = $clog2(DW / 8);
  localparam int LW  = (DSZ > 1) ? DSZ : 1;
  localparam int PW  = $clog2(QDEPTH);
  localparam int CW  = PW + 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    logic [2:0]     size;
    burst_e         burst;
  } cmd_t;

  cmd_t           mem_q [QDEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           rdy_en_q, rdy_en_d;
  state_e         state_q, state_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           err_q, err_d;
  logic [IDW-1:0] id_q, id_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     len_q, len_d;
  logic [2:0]     size_q, size_d;
  burst_e         burst_q, burst_d;

  cmd_t           w_head;
  cmd_t           w_push_cmd;
  logic           w_full, w_empty, w_push, w_pop, w_beat_hs;
  logic           w_head_err, w_cross;
  logic [AW-1:0]  w_next_addr;
  logic [LW-1:0]  w_lane;

  axi_next_addr #(.AW(AW), .DW(DW)) u_next_addr (
    .i_addr      (addr_q),
    .i_size      (size_q),
    .i_len       (len_q),
    .i_burst     (burst_q),
    .o_next_addr (w_next_addr),
    .o_cross     (w_cross),
    .o_lane      (w_lane)
  );

  always_comb begin
    w_full     = (count_q == CW'(QDEPTH));
    w_empty    = (count_q == '0);
    w_push     = bus.i_cmd_valid && bus.o_cmd_ready;
    w_beat_hs  = valid_q && bus.i_beat_ready;
    w_push_cmd = '{id: bus.i_cmd_id, addr: bus.i_cmd_addr, len: bus.i_cmd_len,
                   size: bus.i_cmd_size, burst: burst_e'(bus.i_cmd_burst)};
    w_head     = mem_q[rd_ptr_q];
    w_head_err = (w_head.size > 3'(DSZ)) || (w_head.burst == BURST_RSVD) ||
                 (w_head.burst == BURST_WRAP && !wrap_len_ok(w_head.len)) ||
                 (w_head.burst == BURST_FIXED && w_head.len > 8'd15);
    // Popping on the last handshake is what gives back-to-back bursts no bubble
    w_pop      = !w_empty && ((state_q == ST_IDLE) || (w_beat_hs && last_q));

    rdy_en_d = 1'b1;
    wr_ptr_d = w_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(w_push) - CW'(w_pop);
    state_d  = state_q;
    valid_d  = valid_q;
    last_d   = last_q;
    err_d    = err_q;
    id_d     = id_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;

    if (w_pop) begin
      state_d = ST_RUN;
      valid_d = 1'b1;
      id_d    = w_head.id;
      addr_d  = w_head.addr;
      idx_d   = 8'd0;
      len_d   = w_head.len;
      size_d  = w_head.size;
      last_d  = (w_head.len == 8'd0);
      err_d   = w_head_err;
      burst_d = w_head_err ? BURST_INCR : w_head.burst;
    end else if (w_beat_hs) begin
      if (last_q) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end else begin
        addr_d = w_next_addr;
        idx_d  = idx_q + 8'd1;
        last_d = ((idx_q + 8'd1) == len_q);
        err_d  = err_q | w_cross;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) mem_q[wr_ptr_q] <= w_push_cmd;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= BURST_FIXED;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_en_q <= rdy_en_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      err_q    <= err_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
    end
  end

  assign bus.o_cmd_ready  = rdy_en_q && !w_full;
  assign bus.o_beat_valid = valid_q;
  assign bus.o_beat_id    = id_q;
  assign bus.o_beat_addr  = addr_q;
  assign bus.o_beat_lane  = w_lane;
  assign bus.o_beat_idx   = idx_q;
  assign bus.o_beat_last  = last_q;
  assign bus.o_beat_err   = err_q;
  assign bus.o_busy       = !w_empty || (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_axi_beat_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_beat_gen : scoreboard bench with closed-form burst model   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module tb_axi_beat_gen;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int IDW    = 4;
  localparam int QDEPTH = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [1:0]     lane;
    logic [7:0]     idx;
    logic           last;
    logic           err;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_beat_gen_if #(.AW(AW), .DW(DW), .IDW(IDW)) bus ();

  axi_beat_gen #(.AW(AW), .DW(DW), .IDW(IDW), .QDEPTH(QDEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rdy_mode = 0;
  bit          stall_prev = 1'b0;
  bit          bubble_chk = 1'b0;
  logic [63:0] prev_snap  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected beats from closed-form address of beat k
  function automatic void model_push(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    int unsigned inc, total, lo, alo, base, a_lo;
    bit cerr, e;
    beat_t b;
    inc   = 32'd1 << size;
    total = (int'(len) + 1) * inc;
    lo    = int'(addr[11:0]);
    alo   = lo - (lo % inc);
    base  = lo - (lo % total);
    cerr  = (size > 3'd2) || (burst == 2'd3) ||
            (burst == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
            (burst == 2'd0 && len > 8'd15);
    e = cerr;
    for (int k = 0; k <= int'(len); k++) begin
      if (k == 0 || (!cerr && burst == 2'd0)) a_lo = lo;
      else if (!cerr && burst == 2'd2) a_lo = base + ((alo - base + k * inc) % total);
      else begin
        a_lo = alo + k * inc;
        if (a_lo >= 4096) e = 1'b1;
        a_lo = a_lo % 4096;
      end
      b.id   = id;
      b.addr = {addr[AW-1:12], a_lo[11:0]};
      b.lane = a_lo[1:0];
      b.idx  = 8'(k);
      b.last = (k == int'(len));
      b.err  = e;
      exp_q.push_back(b);
    end
  endfunction

  // Monitor: all DUT sampling on the falling edge
  always @(negedge clk) begin
    beat_t act, exp_b;
    logic [63:0] snap;
    if (!rst_n) begin
      stall_prev = 1'b0;
      bubble_chk = 1'b0;
    end else begin
      snap = {15'd0, bus.o_beat_valid, bus.o_beat_id, bus.o_beat_addr, bus.o_beat_lane,
              bus.o_beat_idx, bus.o_beat_last, bus.o_beat_err};
      if (bubble_chk) begin
        check("no_bubble", 64'(bus.o_beat_valid), 64'd1);
        bubble_chk = 1'b0;
      end
      if (stall_prev) check("hold_stable", snap, prev_snap);
      check("busy", 64'(bus.o_busy), 64'(exp_q.size() != 0));
      if (bus.o_beat_valid && bus.i_beat_ready) begin
        act = '{id: bus.o_beat_id, addr: bus.o_beat_addr, lane: bus.o_beat_lane,
                idx: bus.o_beat_idx, last: bus.o_beat_last, err: bus.o_beat_err};
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(act), 64'd0);
        end else begin
          exp_b = exp_q.pop_front();
          check("beat", 64'(act), 64'(exp_b));
          if (act.last && exp_q.size() != 0) bubble_chk = 1'b1;
        end
      end
      stall_prev = bus.o_beat_valid && !bus.i_beat_ready;
      prev_snap  = snap;
      if (bus.i_cmd_valid && bus.o_cmd_ready)
        model_push(bus.i_cmd_id, bus.i_cmd_addr, bus.i_cmd_len, bus.i_cmd_size, bus.i_cmd_burst);
    end
  end

  initial begin
    bus.i_beat_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.i_beat_ready = 1'b1;
        1:       bus.i_beat_ready = ~bus.i_beat_ready;
        2:       bus.i_beat_ready = 1'($urandom_range(0, 1));
        default: bus.i_beat_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    bit r, acc;
    acc = 1'b0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_id    = id;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_len   = len;
    bus.i_cmd_size  = size;
    bus.i_cmd_burst = burst;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      r = bus.o_cmd_ready;
      @(posedge clk);
      #1;
      acc = r;
    end
    bus.i_cmd_valid = 1'b0;
    check("cmd_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.o_busy) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(t < 4000), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic latency_check(input logic [AW-1:0] addr);
    send(4'h5, addr, 8'd0, 3'd2, 2'd1);
    check("lat_n1_valid", 64'(bus.o_beat_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_n2_valid", 64'(bus.o_beat_valid), 64'd1);
    wait_idle();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [AW-1:0] a;
    logic [7:0]    l;
    logic [1:0]    bst;
    int            sel;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_id    = '0;
    bus.i_cmd_addr  = '0;
    bus.i_cmd_len   = '0;
    bus.i_cmd_size  = '0;
    bus.i_cmd_burst = '0;

    #12;
    check("rst_valid",     64'(bus.o_beat_valid), 64'd0);
    check("rst_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
    check("rst_busy",      64'(bus.o_busy), 64'd0);
    check("rst_fields", 64'({bus.o_beat_id, bus.o_beat_addr, bus.o_beat_lane,
                             bus.o_beat_idx, bus.o_beat_last, bus.o_beat_err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(bus.o_cmd_ready), 64'd1);

    rdy_mode = 0;
    send(4'h1, 32'h0000_1002, 8'd3, 3'd2, 2'd1);
    check("lat_n1_valid", 64'(bus.o_beat_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_n2_valid", 64'(bus.o_beat_valid), 64'd1);
    wait_idle();
    send(4'h2, 32'h0000_0034, 8'd3, 3'd2, 2'd2);  wait_idle();
    send(4'h3, 32'h0000_0FF8, 8'd3, 3'd2, 2'd1);  wait_idle();
    send(4'h4, 32'hABCD_0FF8, 8'd3, 3'd2, 2'd1);  wait_idle();
    send(4'h6, 32'h0000_0100, 8'd2, 3'd3, 2'd1);  wait_idle();
    send(4'h7, 32'h0000_0200, 8'd2, 3'd2, 2'd2);  wait_idle();
    send(4'h8, 32'h0000_0300, 8'd16, 3'd1, 2'd0); wait_idle();
    send(4'h9, 32'h0000_0400, 8'd1, 3'd0, 2'd3);  wait_idle();

    rdy_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    send(4'hA, 32'h0000_1000, 8'd1, 3'd2, 2'd1);
    send(4'hB, 32'h0000_2000, 8'd2, 3'd2, 2'd1);
    send(4'hC, 32'h0000_3000, 8'd0, 3'd2, 2'd1);
    repeat (3) @(negedge clk);
    check("full_ready_low", 64'(bus.o_cmd_ready), 64'd0);
    rdy_mode = 1;
    wait_idle();

    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      bst = (sel < 3) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      l   = 8'($urandom_range(0, 15));
      if (bst == 2'd2 && $urandom_range(0, 3) != 0) l = 8'((2 << $urandom_range(0, 3)) - 1);
      if ($urandom_range(0, 19) == 0) l = 8'($urandom_range(16, 40));
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFE0 | 12'($urandom_range(0, 31));
      send(4'($urandom), a, l, 3'($urandom_range(0, 4)), bst);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();

    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(4'hD, 32'h0000_0100, 8'd7, 3'd2, 2'd1);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (bus.o_beat_valid && bus.o_beat_idx == 8'd2) found = 1'b1;
    end
    check("rst_find_beat2", 64'(found), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_valid", 64'(bus.o_beat_valid), 64'd0);
    check("midrst_busy",  64'(bus.o_busy), 64'd0);
    check("midrst_ready", 64'(bus.o_cmd_ready), 64'd0);
    repeat (2) @(negedge clk);
    check("midrst_hold_valid", 64'(bus.o_beat_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midrst", 64'(bus.o_cmd_ready), 64'd1);
    latency_check(32'h0000_0040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
